pipelined_prefix_adder: RTL and testbench
=========================================

# pipelined_prefix_adder

Parametrised, pipelined Brent-Kung parallel-prefix adder/subtractor with a valid/ready stream interface, pass-through tag and result flags. It is the next-generation arithmetic core for the ALU datapath. It generalises the fixed 32-bit combinational prefix adder to any power-of-two width, with selectable register depth, subtract mode and backpressure. The ALU issue stage feeds it, and the writeback stage consumes it.

## Interface
- `W`, 32: operand width; power of two, 8..128.
- `PIPE`, 1: internal register ranks inside the prefix tree, 0..2. Rank k is placed after prefix level ceil((k+1)·log2(W)/(PIPE+1)).
- `TAG_W`, 4: width of the opaque tag carried with each operation.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  operation accepted when `in_valid & in_ready`.
- `in_a`  in  W  operand A.
- `in_b`  in  W  operand B.
- `in_cin`  in  1  carry-in; ignored when `in_sub`=1.
- `in_sub`  in  1  0: A+B+cin; 1: A−B (A+~B+1).
- `in_tag`  in  TAG_W  returned unchanged with the result.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  result consumed when `out_valid & out_ready`.
- `out_sum`  out  W  sum/difference.
- `out_cout`  out  1  carry out of bit W−1; for SUB, 1 means no borrow.
- `out_ovf`  out  1  signed overflow.
- `out_zero`  out  1  `out_sum`==0.
- `out_tag`  out  TAG_W  tag of this result.

## Operation
- Input rank, on accept: B' = `in_sub` ? ~B : B; c0 = `in_sub` ? 1 : `in_cin`; g=A&B', p=A^B' are registered with c0, tag, and the sign bits of A and B' (needed for ovf).
- Prefix tree: Brent-Kung up-sweep of log2(W) black-cell levels on (g,p) pairs. It is followed by down-sweep grey cells that fold c0 into every carry c[i] (i=1..W). Black and grey cells match the existing team definitions.
- Output rank: sum = p ^ c[W−1:0]; cout = c[W]; ovf = (a_msb==b'_msb) & (sum_msb!=a_msb); zero = ~|sum.
- Each rank holds a valid bit. Global advance enable `en = ~out_valid | out_ready`. All ranks shift together when `en`=1 and hold when `en`=0.
- `in_ready = en`. Bubbles (invalid ranks) are not collapsed and occupy their slot.
- Arithmetic is modulo 2^W. No saturation.

## Timing
- Latency from accept to `out_valid`: exactly PIPE+2 cycles with `out_ready` held high; 3 cycles at default.
- Throughput: one operation per cycle while `out_ready`=1.
- Output stall: `out_*` are held stable, and all ranks freeze, while `out_valid & ~out_ready`. `in_ready` drops in the same cycle, combinationally from `out_ready`.
- An accept and a retire in the same cycle are legal. The new operation enters while the head leaves.
- Reset: all rank valid bits are cleared and all data registers are zeroed. Outputs in the cycle after `rst`: `out_valid`=0, `out_sum`=0, `out_cout`=0, `out_ovf`=0, `out_zero`=0, `out_tag`=0. `in_ready`=1 once `rst` is low.
- Reset mid-operation: in-flight operations are discarded without producing output. `in_valid` is ignored while `rst`=1.
- `in_*` are sampled only on accept. Values presented while `in_ready`=0 have no effect.

## Configuration
- `PREFIX_ADDER_FLAGS_EN` defined: `out_ovf` and `out_zero` are computed as above and pipelined with the result.
- Not defined: flag logic and its pipeline bits are removed. `out_ovf` and `out_zero` are tied to 0, and ports are unchanged. Sum, cout and tag behaviour is identical in both builds.

## Test plan
- W=32, PIPE=1, out_ready=1: A=0xFFFFFFFF, B=0x00000001, sub=0, cin=0, tag=5 -> 3 cycles later: sum=0x00000000, cout=1, zero=1, ovf=0, tag=5.
- SUB with overflow: A=0x80000000, B=0x00000001, sub=1 -> sum=0x7FFFFFFF, cout=1, ovf=1, zero=0. Then A=3, B=5, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0.
- Back-to-back stream: 100 random operations with in_valid=1 every cycle and tags 0..15 cycling -> 100 results in order, one per cycle, all matching a reference model (a+b+cin mod 2^32).
- Backpressure: out_ready=0 for 4 cycles with 3 operations in flight -> out_* stable, in_ready=0 throughout. On release, results drain in order with no loss or duplication.
- Reset mid-stream: assert rst for 1 cycle with 2 operations in flight -> out_valid=0 the next cycle, no stale results, and the next accepted operation returns after PIPE+2 cycles.
- Sweep: W∈{8,64}, PIPE∈{0,2}, both macro settings. Carry-chain case A=all-ones, B=0, cin=1 -> sum=0, cout=1, and latency = PIPE+2.

Source files
------------

// File: rtl/pipelined_prefix_adder.sv
// pipelined_prefix_adder: Brent-Kung adder/subtractor with a valid/ready stream, a pass-through tag and result flags.
// Latency: PIPE+2 cycles from accept to out_valid, with one operation per cycle.
// Backpressure: every rank freezes while out_valid & ~out_ready, and in_ready = ~out_valid | out_ready.
// Build option PREFIX_ADDER_FLAGS_EN: when defined, out_ovf/out_zero are computed; otherwise both are tied to 0.
module pipelined_prefix_adder #(
  parameter int W     = 32,
  parameter int PIPE  = 1,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LG = $clog2(W);
  typedef logic [LG-1:0] idx_t;

  // One tree stage: g/pt evolve through the levels; po (the raw propagate) and c0 are carried for the sum.
  typedef struct packed {
    logic             vld;
    logic             c0;
    logic [W-1:0]     g;
    logic [W-1:0]     pt;
    logic [W-1:0]     po;
    logic [TAG_W-1:0] tag;
`ifdef PREFIX_ADDER_FLAGS_EN
    logic             a_msb;
    logic             b_msb;
`endif
  } stg_t;

  // An internal rank sits after up-sweep level ceil((k+1)*LG/(PIPE+1)) for k = 0..PIPE-1.
  function automatic bit is_bnd(input int lvl);
    bit r;
    r = 1'b0;
    for (int k = 0; k < PIPE; k++) begin
      if ((((k + 1) * LG + PIPE) / (PIPE + 1)) == lvl) r = 1'b1;
    end
    return r;
  endfunction

  // Up-sweep level lvl: black cells on every bit whose index+1 is a multiple of 2^lvl.
  function automatic logic [2*W-1:0] up_level(input logic [W-1:0] g, input logic [W-1:0] p, input int lvl);
    logic [W-1:0] ng;
    logic [W-1:0] np;
    int           j;
    ng = g;
    np = p;
    for (int i = 0; i < W; i++) begin
      if (((i + 1) % (1 << lvl)) == 0) begin
        j = i - (1 << (lvl - 1));
        ng[idx_t'(i)] = g[idx_t'(i)] | (p[idx_t'(i)] & g[idx_t'(j)]);
        np[idx_t'(i)] = p[idx_t'(i)] & p[idx_t'(j)];
      end
    end
    return {ng, np};
  endfunction

  // Down-sweep grey cells: fill in the remaining prefixes; bit 0 already holds c0, so G[i] is c[i+1].
  function automatic logic [W-1:0] down_sweep(input logic [W-1:0] g, input logic [W-1:0] p);
    logic [W-1:0] ng;
    int           j;
    ng = g;
    for (int d = LG - 1; d >= 1; d--) begin
      for (int i = 0; i < W; i++) begin
        if ((((i + 1) % (1 << d)) == (1 << (d - 1))) && ((i + 1) > (1 << d))) begin
          j = i - (1 << (d - 1));
          ng[idx_t'(i)] = ng[idx_t'(i)] | (p[idx_t'(i)] & ng[idx_t'(j)]);
        end
      end
    end
    return ng;
  endfunction

  logic             w_en;
  logic [W-1:0]     w_bx;
  logic             r_in_vld;
  logic             r_in_c0;
  logic [W-1:0]     r_in_g;
  logic [W-1:0]     r_in_p;
  logic [TAG_W-1:0] r_in_tag;
  logic             r_in_amsb;
  logic             r_in_bmsb;
  stg_t             w_tree;
  logic [W-1:0]     w_gf;
  logic [W-1:0]     w_sum;
  logic             w_cout;
  logic             r_out_vld;
  logic [W-1:0]     r_sum;
  logic             r_cout;
  logic [TAG_W-1:0] r_tag;

  assign w_en     = ~r_out_vld | out_ready;
  assign in_ready = w_en;
  assign w_bx     = in_sub ? ~in_b : in_b;

  // Input rank: form g/p from A and the (possibly inverted) B on accept; bubbles only clear the valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_vld  <= 1'b0;
      r_in_c0   <= 1'b0;
      r_in_g    <= '0;
      r_in_p    <= '0;
      r_in_tag  <= '0;
      r_in_amsb <= 1'b0;
      r_in_bmsb <= 1'b0;
    end else if (w_en) begin
      r_in_vld <= in_valid;
      if (in_valid) begin
        r_in_c0   <= in_sub | in_cin;
        r_in_g    <= in_a & w_bx;
        r_in_p    <= in_a ^ w_bx;
        r_in_tag  <= in_tag;
        r_in_amsb <= in_a[W-1];
        r_in_bmsb <= w_bx[W-1];
      end
    end
  end

  for (genvar l = 0; l <= LG; l++) begin : g_lvl
    stg_t w_out;
    if (l == 0) begin : g_in
      // Level 0: fold the carry-in into bit 0 so every later prefix already includes it.
      always_comb begin
        w_out      = '0;
        w_out.vld  = r_in_vld;
        w_out.c0   = r_in_c0;
        w_out.g    = r_in_g;
        w_out.g[0] = r_in_g[0] | (r_in_p[0] & r_in_c0);
        w_out.pt   = r_in_p;
        w_out.po   = r_in_p;
        w_out.tag  = r_in_tag;
`ifdef PREFIX_ADDER_FLAGS_EN
        w_out.a_msb = r_in_amsb;
        w_out.b_msb = r_in_bmsb;
`endif
      end
    end else begin : g_up
      stg_t w_nxt;
      // Up-sweep black-cell level l applied to the previous level's output.
      always_comb begin
        w_nxt = g_lvl[l-1].w_out;
        {w_nxt.g, w_nxt.pt} = up_level(g_lvl[l-1].w_out.g, g_lvl[l-1].w_out.pt, l);
      end
      if (is_bnd(l)) begin : g_reg
        stg_t r_stg;
        // Internal pipeline rank: shifts with the global enable; data is only loaded for valid entries.
        always_ff @(posedge clk) begin
          if (rst) begin
            r_stg <= '0;
          end else if (w_en) begin
            if (w_nxt.vld) r_stg <= w_nxt;
            else           r_stg.vld <= 1'b0;
          end
        end
        assign w_out = r_stg;
      end else begin : g_cmb
        assign w_out = w_nxt;
      end
    end
  end

  assign w_tree = g_lvl[LG].w_out;

  // Down-sweep and sum: c[0] is c0, and c[i+1] is the completed prefix at bit i.
  always_comb begin
    w_gf   = down_sweep(w_tree.g, w_tree.pt);
    w_sum  = w_tree.po ^ {w_gf[W-2:0], w_tree.c0};
    w_cout = w_gf[W-1];
  end

  // Output rank: it holds the result steady while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_vld <= 1'b0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_tag     <= '0;
    end else if (w_en) begin
      r_out_vld <= w_tree.vld;
      if (w_tree.vld) begin
        r_sum  <= w_sum;
        r_cout <= w_cout;
        r_tag  <= w_tree.tag;
      end
    end
  end

`ifdef PREFIX_ADDER_FLAGS_EN
  logic r_ovf;
  logic r_zero;
  // Flag bits share the output rank's enable so they stay aligned with the sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_en && w_tree.vld) begin
      r_ovf  <= (w_tree.a_msb == w_tree.b_msb) & (w_sum[W-1] != w_tree.a_msb);
      r_zero <= ~|w_sum;
    end
  end
  assign out_ovf  = r_ovf;
  assign out_zero = r_zero;
`else
  assign out_ovf  = 1'b0;
  assign out_zero = 1'b0;
`endif

  assign out_valid = r_out_vld;
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;
  assign out_tag   = r_tag;

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Testbench for pipelined_prefix_adder: a directed vector table, a streaming scoreboard,
// backpressure and mid-stream reset sequences, and a carry-chain sweep on W=8/PIPE=0 and W=64/PIPE=2.
module tb_pipelined_prefix_adder;

`ifdef PREFIX_ADDER_FLAGS_EN
  localparam bit FLG = 1'b1;
`else
  localparam bit FLG = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, in_cin, in_sub, out_valid, out_ready;
  logic        out_cout, out_ovf, out_zero;
  logic [31:0] in_a, in_b, out_sum;
  logic [3:0]  in_tag, out_tag;

  logic        s_vld, s_rdy, s_cin, s_sub;
  logic [3:0]  s_tag;
  logic [7:0]  s_a8, s_b8, o_sum8;
  logic [63:0] s_a64, s_b64, o_sum64;
  logic        r8, v8, c8, ov8, z8, r64, v64, c64, ov64, z64;
  logic [3:0]  t8, t64;

  pipelined_prefix_adder #(.W(32), .PIPE(1), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .in_sub(in_sub), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero), .out_tag(out_tag));

  pipelined_prefix_adder #(.W(8), .PIPE(0), .TAG_W(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(s_vld), .in_ready(r8), .in_a(s_a8), .in_b(s_b8),
    .in_cin(s_cin), .in_sub(s_sub), .in_tag(s_tag), .out_valid(v8), .out_ready(s_rdy),
    .out_sum(o_sum8), .out_cout(c8), .out_ovf(ov8), .out_zero(z8), .out_tag(t8));

  pipelined_prefix_adder #(.W(64), .PIPE(2), .TAG_W(4)) dut64 (
    .clk(clk), .rst(rst), .in_valid(s_vld), .in_ready(r64), .in_a(s_a64), .in_b(s_b64),
    .in_cin(s_cin), .in_sub(s_sub), .in_tag(s_tag), .out_valid(v64), .out_ready(s_rdy),
    .out_sum(o_sum64), .out_cout(c64), .out_ovf(ov64), .out_zero(z64), .out_tag(t64));

  typedef struct {
    logic [31:0] a, b;
    logic        cin, sub;
    logic [3:0]  tag;
    logic [31:0] sum;
    logic        cout, ovf, zero;
  } vec_t;

  typedef struct {
    logic [31:0] sum;
    logic        cout, ovf, zero;
    logic [3:0]  tag;
  } res_t;

  res_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   n_ret = 0;
  bit   mon_en = 1'b0;
  vec_t tbl[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: plain modulo-2^32 arithmetic on A + B' + c0.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic cin,
                                 input logic sub, input logic [3:0] tag);
    res_t        r;
    logic [31:0] bb;
    logic [32:0] full;
    bb     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + {32'd0, (sub ? 1'b1 : cin)};
    r.sum  = full[31:0];
    r.cout = full[32];
    r.ovf  = FLG & (a[31] == bb[31]) & (full[31] != a[31]);
    r.zero = FLG & (full[31:0] == 32'd0);
    r.tag  = tag;
    return r;
  endfunction

  task automatic monitor();
    res_t e;
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        if (out_valid && out_ready) begin
          n_ret++;
          chk("stream_queue_nonempty", 64'(q.size() > 0), 64'd1);
          if (q.size() > 0) begin
            e = q.pop_front();
            chk("stream_sum", 64'(out_sum), 64'(e.sum));
            chk("stream_cout", 64'(out_cout), 64'(e.cout));
            chk("stream_ovf", 64'(out_ovf), 64'(e.ovf));
            chk("stream_zero", 64'(out_zero), 64'(e.zero));
            chk("stream_tag", 64'(out_tag), 64'(e.tag));
          end
        end
        if (in_valid && in_ready) q.push_back(model(in_a, in_b, in_cin, in_sub, in_tag));
      end
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       input logic sub, input logic [3:0] tag);
    in_valid = 1'b1;
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_tag = tag;
  endtask

  // Offer one operation, then count cycles from its accepting edge until out_valid (bounded at 20).
  task automatic send_one(input logic [31:0] a, input logic [31:0] b, input logic cin,
                          input logic sub, input logic [3:0] tag, output int lat);
    drive(a, b, cin, sub, tag);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int   lat, lat8, lat64;
    res_t e;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; in_tag = '0;
    s_vld = 1'b0; s_rdy = 1'b1; s_cin = 1'b1; s_sub = 1'b0; s_tag = 4'h3;
    s_a8 = 8'hFF; s_b8 = 8'h00; s_a64 = 64'hFFFF_FFFF_FFFF_FFFF; s_b64 = 64'd0;

    tbl[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 4'd5,  32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 4'd1,  32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{32'h00000003, 32'h00000005, 1'b0, 1'b1, 4'd2,  32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 4'd3,  32'h80000000, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{32'h12345678, 32'h11111111, 1'b1, 1'b0, 4'd4,  32'h2345678A, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{32'h00000005, 32'h00000005, 1'b0, 1'b1, 4'd6,  32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 4'd7,  32'h00000007, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 4'd8,  32'h00000000, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{32'h00000000, 32'h00000001, 1'b0, 1'b1, 4'd9,  32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0, 4'd10, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 4'd11, 32'h00000001, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 4'd12, 32'h00000000, 1'b1, 1'b0, 1'b1};

    fork monitor(); join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_out_cout", 64'(out_cout), 64'd0);
    chk("rst_out_ovf", 64'(out_ovf), 64'd0);
    chk("rst_out_zero", 64'(out_zero), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_in_ready8", 64'(r8), 64'd1);
    chk("rst_in_ready64", 64'(r64), 64'd1);

    // Directed table, one operation at a time
    for (int i = 0; i < 12; i++) begin
      send_one(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, tbl[i].tag, lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
      chk($sformatf("vec%0d_sum", i), 64'(out_sum), 64'(tbl[i].sum));
      chk($sformatf("vec%0d_cout", i), 64'(out_cout), 64'(tbl[i].cout));
      chk($sformatf("vec%0d_ovf", i), 64'(out_ovf), 64'(FLG & tbl[i].ovf));
      chk($sformatf("vec%0d_zero", i), 64'(out_zero), 64'(FLG & tbl[i].zero));
      chk($sformatf("vec%0d_tag", i), 64'(out_tag), 64'(tbl[i].tag));
    end
    @(posedge clk); #1;

    // Back-to-back stream of 100 operations
    mon_en = 1'b1; n_ret = 0;
    for (int k = 0; k < 100; k++) begin
      drive($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)), k[3:0]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("stream_last_valid", 64'(out_valid), 64'd1);
    chk("stream_last_tag", 64'(out_tag), 64'd3);
    chk("stream_one_per_cycle", 64'(n_ret), 64'd99);
    @(posedge clk); #1;
    chk("stream_count", 64'(n_ret), 64'd100);
    chk("stream_drained", 64'(q.size()), 64'd0);

    // Backpressure with three operations in flight
    n_ret = 0;
    drive(32'h10, 32'h20, 1'b0, 1'b0, 4'd1); @(posedge clk); #1;
    drive(32'h100, 32'h1, 1'b1, 1'b0, 4'd2); @(posedge clk); #1;
    drive(32'h9, 32'h4, 1'b0, 1'b1, 4'd3);   @(posedge clk); #1;
    out_ready = 1'b0;
    drive(32'h1, 32'h1, 1'b0, 1'b0, 4'd4);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("stall%0d_in_ready", k), 64'(in_ready), 64'd0);
      chk($sformatf("stall%0d_valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("stall%0d_sum", k), 64'(out_sum), 64'h30);
      chk($sformatf("stall%0d_tag", k), 64'(out_tag), 64'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1; in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("stall_drain_count", 64'(n_ret), 64'd3);
    chk("stall_drained", 64'(q.size()), 64'd0);

    // Reset with two operations in flight
    mon_en = 1'b0;
    drive(32'h1, 32'h2, 1'b0, 1'b0, 4'd6); @(posedge clk); #1;
    drive(32'h3, 32'h4, 1'b0, 1'b0, 4'd7); @(posedge clk); #1;
    rst = 1'b1;
    drive(32'hDEAD, 32'h1, 1'b0, 1'b0, 4'd9);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_sum", 64'(out_sum), 64'd0);
    chk("midrst_tag", 64'(out_tag), 64'd0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("midrst_stale%0d", k), 64'(out_valid), 64'd0);
    end
    send_one(32'd100, 32'd23, 1'b0, 1'b0, 4'hA, lat);
    chk("postrst_latency", 64'(lat), 64'd3);
    chk("postrst_sum", 64'(out_sum), 64'd123);
    chk("postrst_tag", 64'(out_tag), 64'hA);
    e = model(32'd100, 32'd23, 1'b0, 1'b0, 4'hA);
    chk("postrst_cout", 64'(out_cout), 64'(e.cout));
    @(posedge clk); #1;

    // Carry-chain sweep on the W=8/PIPE=0 and W=64/PIPE=2 instances
    s_vld = 1'b1;
    @(posedge clk); #1;
    s_vld = 1'b0;
    lat8 = 0; lat64 = 0;
    for (int c = 1; c <= 8; c++) begin
      if (v8 && lat8 == 0) begin
        lat8 = c;
        chk("w8_sum", 64'(o_sum8), 64'd0);
        chk("w8_cout", 64'(c8), 64'd1);
        chk("w8_zero", 64'(z8), 64'(FLG));
        chk("w8_ovf", 64'(ov8), 64'd0);
        chk("w8_tag", 64'(t8), 64'd3);
      end
      if (v64 && lat64 == 0) begin
        lat64 = c;
        chk("w64_sum", o_sum64, 64'd0);
        chk("w64_cout", 64'(c64), 64'd1);
        chk("w64_zero", 64'(z64), 64'(FLG));
        chk("w64_ovf", 64'(ov64), 64'd0);
        chk("w64_tag", 64'(t64), 64'd3);
      end
      @(posedge clk); #1;
    end
    chk("w8_latency", 64'(lat8), 64'd2);
    chk("w64_latency", 64'(lat64), 64'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
